branch_predictor: RTL and testbench

//  Dynamic branch predictor for the fetch stage: a small fully-associative

---
 rtl/bp_pkg.sv | 23 ++
 rtl/branch_predictor_if.sv | 20 ++
 rtl/bp_btb_cam.sv | 26 ++
 rtl/branch_predictor.sv | 86 ++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: BTB entry layout, 2-bit counter constants and saturating helpers.
package bp_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  cnt;
    } bp_entry_t;

    localparam logic [1:0] CNT_WEAK_T = 2'b10;
    localparam logic [1:0] CNT_MAX    = 2'b11;
    localparam logic [1:0] CNT_MIN    = 2'b00;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CNT_MIN) ? CNT_MIN : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch/decode/execute signals shared with the predictor.
interface branch_predictor_if;
    logic [31:0] target_addr;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic        d_is_branch;
    logic        x_predict_res;
    logic [31:0] f_predict_addr;
    logic        f_predict_valid;

    modport master (
        output target_addr, f_pc, d_pc, d_is_branch, x_predict_res,
        input  f_predict_addr, f_predict_valid
    );

    modport slave (
        input  target_addr, f_pc, d_pc, d_is_branch, x_predict_res,
        output f_predict_addr, f_predict_valid
    );
endinterface

// File: rtl/bp_btb_cam.sv
// bp_btb_cam: parallel 32-bit tag compare across all BTB entries.
module bp_btb_cam
    import bp_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  bp_entry_t [ENTRIES-1:0]         tbl_i,
    input  logic [31:0]                     pc_i,
    output logic                            hit_o,
    output logic [$clog2(ENTRIES)-1:0]      idx_o
);
    logic [ENTRIES-1:0] match;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
        assign match[g] = tbl_i[g].valid && (tbl_i[g].pc == pc_i);
    end

    assign hit_o = |match;

    // Allocation never duplicates a PC, so OR-encoding the one-hot is exact.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (match[i]) idx_o = idx_o | ($clog2(ENTRIES))'(i);
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fully-associative BTB with 2-bit counters; decode-time
// branch info is piped to the execute resolve cycle, where the table updates.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int X_LAT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int IW = $clog2(ENTRIES);

    bp_entry_t [ENTRIES-1:0] tbl_q, tbl_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [X_LAT-1:0]        pv_q;
    logic [X_LAT-1:0][31:0]  ppc_q, ptg_q;

    logic          f_hit, r_hit, free_hit, res;
    logic [IW-1:0] f_idx, r_idx, free_idx, victim;

    bp_btb_cam #(.ENTRIES(ENTRIES)) u_f_cam (
        .tbl_i (tbl_q),
        .pc_i  (bp.f_pc),
        .hit_o (f_hit),
        .idx_o (f_idx)
    );

    bp_btb_cam #(.ENTRIES(ENTRIES)) u_r_cam (
        .tbl_i (tbl_q),
        .pc_i  (ppc_q[X_LAT-1]),
        .hit_o (r_hit),
        .idx_o (r_idx)
    );

    // Lowest-index invalid entry wins; descending scan leaves the lowest last.
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!tbl_q[i].valid) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
    end

    assign res    = pv_q[X_LAT-1];
    assign victim = free_hit ? free_idx : rr_q;

    always_comb begin
        tbl_d = tbl_q;
        rr_d  = rr_q;
        if (res && r_hit) begin
            tbl_d[r_idx].cnt = bp.x_predict_res ? sat_inc(tbl_q[r_idx].cnt) : sat_dec(tbl_q[r_idx].cnt);
            if (bp.x_predict_res) tbl_d[r_idx].target = ptg_q[X_LAT-1];
        end else if (res && bp.x_predict_res) begin
            tbl_d[victim] = '{valid: 1'b1, pc: ppc_q[X_LAT-1], target: ptg_q[X_LAT-1], cnt: CNT_WEAK_T};
            rr_d = free_hit ? rr_q : rr_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_q <= '0;
            rr_q  <= '0;
            pv_q  <= '0;
            ppc_q <= '0;
            ptg_q <= '0;
        end else begin
            tbl_q    <= tbl_d;
            rr_q     <= rr_d;
            pv_q[0]  <= bp.d_is_branch;
            ppc_q[0] <= bp.d_pc;
            ptg_q[0] <= bp.target_addr;
            for (int i = 1; i < X_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                ppc_q[i] <= ppc_q[i-1];
                ptg_q[i] <= ptg_q[i-1];
            end
        end
    end

    assign bp.f_predict_valid = !reset && f_hit && (tbl_q[f_idx].cnt >= CNT_WEAK_T);
    assign bp.f_predict_addr  = bp.f_predict_valid ? tbl_q[f_idx].target : 32'h0;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench driving a behavioural BTB model.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(4), .X_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if)
    );

    typedef struct {
        logic        v;
        logic [31:0] a;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    logic        mv[4];
    logic [31:0] mpc[4], mtg[4];
    logic [1:0]  mcnt[4];
    int          mrr;
    logic        pv[2];
    logic [31:0] ppc[2], ptg[2];
    logic        last_v;
    logic [31:0] last_a;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_update(input logic br, input logic [31:0] dpc, input logic [31:0] tg,
                                input logic xr, input logic rs);
        int hi, vi;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 1'b0;
                mcnt[i] = 2'd0;
            end
            mrr = 0;
            pv[0] = 1'b0;
            pv[1] = 1'b0;
            return;
        end
        if (pv[1]) begin
            hi = -1;
            for (int i = 0; i < 4; i++)
                if (mv[i] && mpc[i] == ppc[1]) hi = i;
            if (hi >= 0) begin
                if (xr) begin
                    mcnt[hi] = (mcnt[hi] == 2'd3) ? 2'd3 : mcnt[hi] + 2'd1;
                    mtg[hi] = ptg[1];
                end else begin
                    mcnt[hi] = (mcnt[hi] == 2'd0) ? 2'd0 : mcnt[hi] - 2'd1;
                end
            end else if (xr) begin
                vi = -1;
                for (int i = 3; i >= 0; i--)
                    if (!mv[i]) vi = i;
                if (vi < 0) begin
                    vi = mrr;
                    mrr = (mrr + 1) % 4;
                end
                mv[vi] = 1'b1;
                mpc[vi] = ppc[1];
                mtg[vi] = ptg[1];
                mcnt[vi] = 2'd2;
            end
        end
        pv[1] = pv[0];
        ppc[1] = ppc[0];
        ptg[1] = ptg[0];
        pv[0] = br;
        ppc[0] = dpc;
        ptg[0] = tg;
    endtask

    task automatic step(input logic [31:0] fpc, input logic br, input logic [31:0] dpc,
                        input logic [31:0] tg, input logic xr, input logic rs);
        exp_t e;
        @(negedge clk);
        bp_if.f_pc = fpc;
        bp_if.d_is_branch = br;
        bp_if.d_pc = dpc;
        bp_if.target_addr = tg;
        bp_if.x_predict_res = xr;
        reset = rs;
        e.v = 1'b0;
        e.a = 32'h0;
        if (!rs)
            for (int i = 0; i < 4; i++)
                if (mv[i] && mpc[i] == fpc && mcnt[i] >= 2'd2) begin
                    e.v = 1'b1;
                    e.a = mtg[i];
                end
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        last_v = bp_if.f_predict_valid;
        last_a = bp_if.f_predict_addr;
        check("pred_valid", {31'b0, last_v}, {31'b0, e.v});
        check("pred_addr", last_a, e.a);
        @(posedge clk);
        model_update(br, dpc, tg, xr, rs);
    endtask

    task automatic idle(input logic [31:0] fpc, input logic xr);
        step(fpc, 1'b0, 32'h0, 32'h0, xr, 1'b0);
    endtask

    initial begin
        step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("reset_valid", {31'b0, last_v}, 32'h0);

        for (int i = 0; i < 7; i++) idle(32'h1000 + 32'(4 * i), 1'b0);

        step(32'h1000, 1'b1, 32'h1008, 32'h1010, 1'b0, 1'b0);
        idle(32'h1004, 1'b0);
        idle(32'h1008, 1'b0);
        idle(32'h1008, 1'b1);
        check("t2_nt_no_alloc", {31'b0, last_v}, 32'h0);

        step(32'h0, 1'b1, 32'h100c, 32'h1014, 1'b0, 1'b0);
        idle(32'h100c, 1'b0);
        idle(32'h100c, 1'b1);
        check("t3_pre_update", {31'b0, last_v}, 32'h0);
        idle(32'h100c, 1'b0);
        check("t3_valid", {31'b0, last_v}, 32'h1);
        check("t3_addr", last_a, 32'h1014);

        step(32'h0, 1'b1, 32'h1014, 32'h1000, 1'b0, 1'b0);
        idle(32'h0, 1'b0);
        idle(32'h0, 1'b1);
        step(32'h1014, 1'b1, 32'h1014, 32'h1000, 1'b0, 1'b0);
        check("t4_alloc", last_a, 32'h1000);
        idle(32'h1014, 1'b0);
        step(32'h1014, 1'b1, 32'h1014, 32'h1000, 1'b1, 1'b0);
        step(32'h1014, 1'b1, 32'h1014, 32'h1000, 1'b0, 1'b0);
        idle(32'h1014, 1'b0);
        idle(32'h1014, 1'b0);
        check("t4_cnt2_valid", {31'b0, last_v}, 32'h1);
        idle(32'h1014, 1'b0);
        check("t4_cnt1_valid", {31'b0, last_v}, 32'h0);
        idle(32'h100c, 1'b0);
        check("t4_other_kept", last_a, 32'h1014);

        step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(32'h0, 1'b1, 32'h2000 + 32'(4 * i), 32'h2800 + 32'(4 * i), 1'b1, 1'b0);
        idle(32'h0, 1'b1);
        idle(32'h0, 1'b1);
        idle(32'h2000, 1'b0);
        check("t5_evicted", {31'b0, last_v}, 32'h0);
        for (int i = 1; i < 5; i++) begin
            idle(32'h2000 + 32'(4 * i), 1'b0);
            check("t5_hit_addr", last_a, 32'h2800 + 32'(4 * i));
        end

        step(32'h0, 1'b1, 32'h3000, 32'h3100, 1'b1, 1'b0);
        idle(32'h0, 1'b1);
        idle(32'h3000, 1'b1);
        check("t6_same_cycle_old", {31'b0, last_v}, 32'h0);
        idle(32'h3000, 1'b0);
        check("t6_next_cycle_new", last_a, 32'h3100);
        step(32'h3000, 1'b1, 32'h3008, 32'h3200, 1'b1, 1'b0);
        step(32'h3000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        check("t6_reset_gate", {31'b0, last_v}, 32'h0);
        idle(32'h3008, 1'b1);
        idle(32'h3008, 1'b1);
        check("t6_discarded", {31'b0, last_v}, 32'h0);
        idle(32'h3000, 1'b0);
        check("t6_cleared", {31'b0, last_v}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
